// File: rtl/endec_pkg.sv
// Shared types and default widths for the stream front end of the encoder/decoder core.
package endec_pkg;

  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_CFG_W  = 64;
  localparam int unsigned DEF_IN_W   = 512;
  localparam int unsigned DEF_OUT_W  = 512;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [2:0] {
    S_CFG,
    S_PAY,
    S_DRAIN,
    S_START,
    S_WAIT,
    S_SEND
  } state_t;

endpackage

// File: rtl/axis_piso.sv
// Parallel-in/serial-out AXI-Stream transmitter: loads a wide word and emits it MSB-first,
// with tlast on the final beat.
module axis_piso #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OUT_W  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [OUT_W-1:0]  load_data,
  output logic [DATA_W-1:0] tdata,
  output logic              tvalid,
  output logic              tlast,
  input  logic              tready,
  output logic              last_xfer
);

  localparam int unsigned BEATS = OUT_W / DATA_W;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [OUT_W-1:0] sreg_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             at_last;

  assign at_last = (cnt_q == CW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load) begin
      sreg_q <= load_data;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q && tready) begin
      sreg_q <= sreg_q << DATA_W;
      cnt_q  <= cnt_q + 1'b1;
      if (at_last) busy_q <= 1'b0;
    end
  end

  assign tdata     = sreg_q[OUT_W-1 -: DATA_W];
  assign tvalid    = busy_q;
  assign tlast     = busy_q && at_last;
  assign last_xfer = busy_q && tready && at_last;

endmodule

// File: rtl/axis_frame_bridge.sv
// AXI-Stream front end: deserialises a cfg beat plus payload packet for the core, then
// serialises the core result back out, with framing-error detection and status counters.
module axis_frame_bridge
  import endec_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CFG_W  = DEF_CFG_W,
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [CFG_W-1:0]  o_cfg,
  output logic [IN_W-1:0]   o_frame,
  output logic              o_start,
  input  logic              i_done,
  input  logic [OUT_W-1:0]  i_result,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_frames_ok,
  output logic [CNT_W-1:0]  o_err_count
);

  localparam int unsigned BEATS_IN = IN_W / DATA_W;
  localparam int unsigned BW       = (BEATS_IN > 1) ? $clog2(BEATS_IN) : 1;

  if (IN_W % DATA_W != 0) begin : g_bad_in_w
    $error("IN_W must be a multiple of DATA_W");
  end
  if (OUT_W % DATA_W != 0) begin : g_bad_out_w
    $error("OUT_W must be a multiple of DATA_W");
  end
  if (CFG_W > DATA_W) begin : g_bad_cfg_w
    $error("CFG_W must not exceed DATA_W");
  end

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q;
  logic [CFG_W-1:0]  cfg_q;
  logic [IN_W-1:0]   frame_q;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  frames_ok_q, err_count_q;
  logic              in_xfer, pay_last, piso_load, piso_done;

  assign in_xfer  = s_axis_tvalid && s_axis_tready;
  assign pay_last = (beat_q == BW'(BEATS_IN - 1));

  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= S_CFG;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CFG:   if (in_xfer) state_d = s_axis_tlast ? S_PAY : S_DRAIN;
      S_PAY: begin
        if (in_xfer) begin
          if (s_axis_tlast) state_d = pay_last ? S_START : S_CFG;
          else if (pay_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (in_xfer && s_axis_tlast) state_d = S_CFG;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (i_done) state_d = S_SEND;
      S_SEND:  if (piso_done) state_d = S_CFG;
      default: state_d = S_CFG;
    endcase
  end

  always_comb begin
    s_axis_tready = !rst && (state_q inside {S_CFG, S_PAY, S_DRAIN});
    o_start       = (state_q == S_START);
    piso_load     = (state_q == S_WAIT) && i_done;
    err_d         = 1'b0;
    // A payload tlast is an error unless it lands exactly on the last beat, and vice versa.
    if (in_xfer) begin
      if (state_q == S_CFG) err_d = !s_axis_tlast;
      if (state_q == S_PAY) err_d = (s_axis_tlast != pay_last);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      beat_q      <= '0;
      cfg_q       <= '0;
      frame_q     <= '0;
      err_q       <= 1'b0;
      frames_ok_q <= '0;
      err_count_q <= '0;
    end else begin
      err_q <= err_d;
      if (err_d && (err_count_q != '1)) err_count_q <= err_count_q + 1'b1;
      if (piso_done && (frames_ok_q != '1)) frames_ok_q <= frames_ok_q + 1'b1;
      if ((state_q == S_CFG) && in_xfer && s_axis_tlast) begin
        cfg_q  <= s_axis_tdata[CFG_W-1:0];
        beat_q <= '0;
      end
      if ((state_q == S_PAY) && in_xfer) begin
        frame_q[(BEATS_IN - 1 - beat_q) * DATA_W +: DATA_W] <= s_axis_tdata;
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  axis_piso #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_piso (
    .clk       (sys_clk),
    .rst       (rst),
    .load      (piso_load),
    .load_data (i_result),
    .tdata     (m_axis_tdata),
    .tvalid    (m_axis_tvalid),
    .tlast     (m_axis_tlast),
    .tready    (m_axis_tready),
    .last_xfer (piso_done)
  );

  assign o_cfg       = cfg_q;
  assign o_frame     = frame_q;
  assign o_err       = err_q;
  assign o_frames_ok = frames_ok_q;
  assign o_err_count = err_count_q;

endmodule

// File: tb/tb_axis_frame_bridge.sv
// Directed bench for axis_frame_bridge: nominal, backpressure, framing errors and reset.
module tb_axis_frame_bridge;

  logic         sys_clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic [63:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready = 1'b1;
  logic [63:0]  o_cfg;
  logic [511:0] o_frame;
  logic         o_start;
  logic         i_done = 1'b0;
  logic [511:0] i_result = '0;
  logic         o_err;
  logic [15:0]  o_frames_ok;
  logic [15:0]  o_err_count;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  axis_frame_bridge dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .o_cfg         (o_cfg),
    .o_frame       (o_frame),
    .o_start       (o_start),
    .i_done        (i_done),
    .i_result      (i_result),
    .o_err         (o_err),
    .o_frames_ok   (o_frames_ok),
    .o_err_count   (o_err_count)
  );

  function automatic logic [63:0] pay(input int k);
    logic [3:0] nib;
    nib = 4'(k + 1);
    return {16{nib}};
  endfunction

  function automatic logic [511:0] pay_frame();
    logic [511:0] f;
    for (int k = 0; k < 8; k++) f[511 - k*64 -: 64] = pay(k);
    return f;
  endfunction

  function automatic logic [511:0] result_frame();
    logic [511:0] r;
    logic [7:0]   b;
    for (int k = 0; k < 8; k++) begin
      b = 8'hA0 + 8'(k);
      r[511 - k*64 -: 64] = {8{b}};
    end
    return r;
  endfunction

  // Drives one input beat and returns #1 after the edge on which it transferred.
  task automatic axis_send(input logic [63:0] d, input logic l);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = l;
    while (!s_axis_tready && n < 50) begin
      @(posedge sys_clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL axis_send_timeout: tready=%b required 1", s_axis_tready);
    end
    @(posedge sys_clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    rst = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  // Collects nbeats output beats, comparing each valid cycle against the model.
  task automatic recv(input logic [511:0] exp, input bit bp, input int nbeats, output int cyc);
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   idx = 0;
    logic acc;
    cyc = 0;
    while (idx < nbeats && cyc < 200) begin
      m_axis_tready = bp ? pat[cyc % 4] : 1'b1;
      if (m_axis_tvalid) begin
        checks++;
        if (m_axis_tdata !== exp[511 - idx*64 -: 64]) begin
          errors++;
          $display("FAIL out_beat%0d_data: got %h required %h", idx, m_axis_tdata,
                   exp[511 - idx*64 -: 64]);
        end
        checks++;
        if (m_axis_tlast !== (idx == 7)) begin
          errors++;
          $display("FAIL out_beat%0d_last: got %b required %b", idx, m_axis_tlast, idx == 7);
        end
      end
      acc = m_axis_tvalid && m_axis_tready;
      @(posedge sys_clk); #1;
      cyc++;
      if (acc) idx++;
    end
    m_axis_tready = 1'b1;
    checks++;
    if (idx != nbeats) begin
      errors++;
      $display("FAIL recv_timeout: got %0d beats required %0d", idx, nbeats);
    end
  endtask

  task automatic full_frame(input logic [63:0] cfg, input bit bp, input logic [15:0] exp_ok);
    int cyc;
    axis_send(cfg, 1'b1);
    for (int k = 0; k < 8; k++) axis_send(pay(k), k == 7);
    checks++;
    if (o_start !== 1'b1) begin
      errors++; $display("FAIL start_pulse: got %b required 1", o_start);
    end
    checks++;
    if (o_cfg !== cfg) begin
      errors++; $display("FAIL cfg_latch: got %h required %h", o_cfg, cfg);
    end
    checks++;
    if (o_frame !== pay_frame()) begin
      errors++; $display("FAIL frame_latch: got %h required %h", o_frame, pay_frame());
    end
    @(posedge sys_clk); #1;
    checks++;
    if (o_start !== 1'b0 || s_axis_tready !== 1'b0) begin
      errors++; $display("FAIL start_once: start=%b tready=%b required 0 0", o_start, s_axis_tready);
    end
    i_result = result_frame();
    i_done   = 1'b1;
    @(posedge sys_clk); #1;
    i_done = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++; $display("FAIL first_valid_latency: got %b required 1", m_axis_tvalid);
    end
    recv(result_frame(), bp, 8, cyc);
    if (!bp) begin
      checks++;
      if (cyc != 8) begin
        errors++; $display("FAIL send_cycles: got %0d required 8", cyc);
      end
    end
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
      errors++;
      $display("FAIL valid_drop: valid=%b last=%b required 0 0", m_axis_tvalid, m_axis_tlast);
    end
    checks++;
    if (o_frames_ok !== exp_ok) begin
      errors++; $display("FAIL frames_ok: got %0d required %0d", o_frames_ok, exp_ok);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    checks++;
    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 ||
        o_start !== 1'b0 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: tready=%b tvalid=%b tlast=%b start=%b err=%b required all 0",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, o_start, o_err);
    end
    checks++;
    if (o_cfg !== '0 || o_frame !== '0 || m_axis_tdata !== '0 || o_frames_ok !== '0 ||
        o_err_count !== '0) begin
      errors++;
      $display("FAIL reset_data: cfg=%h tdata=%h ok=%0d errc=%0d required all 0",
               o_cfg, m_axis_tdata, o_frames_ok, o_err_count);
    end
    rst = 1'b0;
    @(posedge sys_clk); #1;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL idle_tready: got %b required 1", s_axis_tready);
    end
  endtask

  task automatic test_missing_cfg_tlast();
    do_reset();
    axis_send(64'h0000_0000_0000_1234, 1'b0);
    checks++;
    if (o_err !== 1'b1 || o_err_count !== 16'd1) begin
      errors++; $display("FAIL cfg_no_last_err: err=%b count=%0d required 1 1", o_err, o_err_count);
    end
    axis_send(64'h55, 1'b0);
    checks++;
    if (o_err !== 1'b0) begin
      errors++; $display("FAIL err_pulse_width: got %b required 0", o_err);
    end
    axis_send(64'h66, 1'b1);
    checks++;
    if (o_cfg !== '0) begin
      errors++; $display("FAIL cfg_unchanged: got %h required 0", o_cfg);
    end
    axis_send(64'h0000_0000_0000_00C5, 1'b1);
    checks++;
    if (o_cfg !== 64'hC5) begin
      errors++; $display("FAIL resync_cfg: got %h required c5", o_cfg);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    full_frame(64'h0000_0000_0BDB_3BED, 1'b0, 16'd1);
  endtask

  task automatic test_backpressure();
    do_reset();
    full_frame(64'h0000_0000_0000_0042, 1'b1, 16'd1);
  endtask

  task automatic test_short_packet();
    do_reset();
    axis_send(64'h0000_0000_0000_0077, 1'b1);
    for (int k = 0; k < 3; k++) axis_send(pay(k), k == 2);
    checks++;
    if (o_err !== 1'b1 || o_err_count !== 16'd1) begin
      errors++; $display("FAIL short_err: err=%b count=%0d required 1 1", o_err, o_err_count);
    end
    checks++;
    if (o_start !== 1'b0) begin
      errors++; $display("FAIL short_no_start: got %b required 0", o_start);
    end
    i_result = result_frame();
    i_done   = 1'b1;
    @(posedge sys_clk); #1;
    i_done = 1'b0;
    @(posedge sys_clk); #1;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL done_ignored: got %b required 0", m_axis_tvalid);
    end
    full_frame(64'h0000_0000_0BDB_3BED, 1'b0, 16'd1);
    checks++;
    if (o_err_count !== 16'd1) begin
      errors++; $display("FAIL short_err_count: got %0d required 1", o_err_count);
    end
  endtask

  task automatic test_long_packet();
    do_reset();
    axis_send(64'h0000_0000_0000_0099, 1'b1);
    for (int k = 0; k < 8; k++) axis_send(pay(k), 1'b0);
    checks++;
    if (o_err !== 1'b1) begin
      errors++; $display("FAIL long_err: got %b required 1", o_err);
    end
    axis_send(64'hDEAD, 1'b0);
    axis_send(64'hBEEF, 1'b1);
    checks++;
    if (o_start !== 1'b0 || o_err_count !== 16'd1) begin
      errors++;
      $display("FAIL long_drain: start=%b count=%0d required 0 1", o_start, o_err_count);
    end
    full_frame(64'h0000_0000_0000_ABCD, 1'b0, 16'd1);
  endtask

  task automatic test_reset_mid_send();
    int cyc;
    do_reset();
    axis_send(64'h0000_0000_0000_0011, 1'b1);
    for (int k = 0; k < 8; k++) axis_send(pay(k), k == 7);
    @(posedge sys_clk); #1;
    i_result = result_frame();
    i_done   = 1'b1;
    @(posedge sys_clk); #1;
    i_done = 1'b0;
    recv(result_frame(), 1'b0, 3, cyc);
    rst = 1'b1;
    @(posedge sys_clk); #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
      errors++;
      $display("FAIL rst_send_valid: valid=%b last=%b required 0 0", m_axis_tvalid, m_axis_tlast);
    end
    checks++;
    if (o_frames_ok !== '0 || o_err_count !== '0 || o_cfg !== '0) begin
      errors++;
      $display("FAIL rst_send_state: ok=%0d errc=%0d cfg=%h required 0 0 0",
               o_frames_ok, o_err_count, o_cfg);
    end
    rst = 1'b0;
    @(posedge sys_clk); #1;
    full_frame(64'h0000_0000_0BDB_3BED, 1'b0, 16'd1);
  endtask

  initial begin
    test_reset();
    test_missing_cfg_tlast();
    test_nominal();
    test_backpressure();
    test_short_packet();
    test_long_packet();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_frame_bridge.md
Name: axis_frame_bridge

Overview:
- Parametrised AXI4-Stream front end between the host DMA stream and the encoder/decoder core.
- Accepts a one-beat configuration packet followed by a multi-beat payload packet, packed MSB-first, and presents both to the core with a one-cycle start pulse.
- Captures the core result and serialises it back out MSB-first, with tlast on the final beat.
- Adds framing-error detection, drain/resync, backpressure tolerance and status counters.

Parameters:
- DATA_W, 64, AXI-Stream tdata width.
- CFG_W, 64, configuration word width (CFG_W <= DATA_W); taken from tdata[CFG_W-1:0].
- IN_W, 512, payload frame width (multiple of DATA_W); BEATS_IN = IN_W/DATA_W.
- OUT_W, 512, result frame width (multiple of DATA_W); BEATS_OUT = OUT_W/DATA_W.
- CNT_W, 16, status counter width.

Ports:
- sys_clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- s_axis_tdata, in, DATA_W, input stream data.
- s_axis_tvalid, in, 1, input stream valid.
- s_axis_tlast, in, 1, input stream packet end.
- s_axis_tready, out, 1, input stream ready.
- m_axis_tdata, out, DATA_W, output stream data.
- m_axis_tvalid, out, 1, output stream valid.
- m_axis_tlast, out, 1, output stream packet end.
- m_axis_tready, in, 1, output stream ready.
- o_cfg, out, CFG_W, latched configuration word.
- o_frame, out, IN_W, latched payload frame.
- o_start, out, 1, one-cycle pulse: cfg/frame valid, core may begin.
- i_done, in, 1, core result valid (single-cycle pulse).
- i_result, in, OUT_W, core result, sampled on i_done.
- o_err, out, 1, one-cycle pulse on each framing error.
- o_frames_ok, out, CNT_W, completed frames (saturating).
- o_err_count, out, CNT_W, framing errors (saturating).

Behaviour:
- Reset: state S_CFG; s_axis_tready, m_axis_tvalid, m_axis_tlast, o_start and o_err are 0; o_cfg, o_frame, m_axis_tdata and both counters are 0.
- Handshake: a beat transfers on tvalid&tready. Registered outputs (m_axis_tdata/tvalid/tlast) hold stable while stalled.
- States:
  - S_CFG, tready=1. A beat with tlast=1 latches o_cfg and goes to S_PAY with beat count 0. A beat with tlast=0 raises o_err and goes to S_DRAIN.
  - S_PAY, tready=1. Beat k is written to o_frame[IN_W-1-k*DATA_W -: DATA_W].
    - tlast on k == BEATS_IN-1: go to S_START.
    - tlast on k < BEATS_IN-1 (short packet): o_err, back to S_CFG; o_frame is partially overwritten, which is acceptable.
    - No tlast on k == BEATS_IN-1 (long packet): o_err, go to S_DRAIN.
  - S_DRAIN, tready=1. Discard beats; the beat carrying tlast returns to S_CFG.
  - S_START, tready=0. o_start=1 for exactly one cycle, then S_WAIT.
  - S_WAIT, tready=0. On i_done, load the shift register from i_result, clear the beat count, go to S_SEND.
  - S_SEND. m_axis_tvalid=1; tdata = sreg[OUT_W-1 -: DATA_W]. On handshake, shift sreg left by DATA_W and increment the count. tlast=1 exactly when count == BEATS_OUT-1. The final handshake drops tvalid/tlast next cycle, increments o_frames_ok, and returns to S_CFG.
- Latency:
  - Last payload handshake at cycle N gives o_start high in cycle N+1.
  - i_done at cycle M gives first m_axis_tvalid in cycle M+1.
  - With tready held at 1, a full result takes BEATS_OUT cycles.
- i_done outside S_WAIT is ignored.
- o_cfg and o_frame hold until overwritten by the next packet.
- o_err_count increments on every o_err. Both counters saturate at all-ones.
- Synchronous rst mid-packet or mid-send: return to reset values next edge. Any partial frame is discarded and no tlast is emitted.
- Elaboration assertions: IN_W % DATA_W == 0, OUT_W % DATA_W == 0, CFG_W <= DATA_W.

Decomposition:
- Shared package endec_pkg: state enum typedef (S_CFG, S_PAY, S_DRAIN, S_START, S_WAIT, S_SEND) and the default width constants alongside the existing param_def macros.
- One natural sub-module: axis_piso, the parametrised parallel-in/serial-out transmitter used for S_SEND. Deserialisation stays inline.

Test Plan:
- Nominal: cfg beat 0x000000000BDB3BED with tlast, then 8 payload beats 0x1111..1111 through 0x8888..8888, tlast on the 8th.
  - Expect o_cfg = 0x0BDB3BED and o_frame[511:448] = 0x1111..1111.
  - Expect o_start one cycle after the 8th handshake.
  - Model returns i_result = {8 beats 0xA0..A7 replicated}; output matches MSB-first, tlast only on beat 8, o_frames_ok = 1.
- Backpressure: m_axis_tready toggles 1,0,0,1 pattern -> tdata/tvalid stable during stalls, 8 beats delivered in order, no duplicates.
- Short packet: tlast on payload beat 3 -> o_err pulse, o_err_count = 1, no o_start. A following good cfg+payload completes normally.
- Long packet: 10 payload beats, tlast on beat 10 -> o_err at beat 8, beats 9-10 drained, next cfg accepted, o_err_count = 1.
- Missing cfg tlast: cfg beat with tlast=0 then 2 beats ending in tlast -> o_err, drain, state back to S_CFG, o_cfg unchanged (0).
- Reset mid-send: assert rst after output beat 3 -> m_axis_tvalid = 0 next cycle, counters 0; a fresh frame then completes with o_frames_ok = 1.
